mips_cpu_hilo_issue: RTL
========================

MIPS_CPU_HILO_ISSUE -- requirements
Module: mips_cpu_hilo_issue

Interface
REQ-001 SHALL have a single clock, and reset SHALL be asynchronous and active-high.
REQ-002 SHALL have parameter DIV_TIMEOUT, default 40, giving the maximum DIV_RUN cycles before abort.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  async active-high reset.
REQ-005 instr_valid  in  1  upstream offers an HI/LO-class R-type instruction.
REQ-006 funct  in  6  instruction funct field.
REQ-007 rs_data  in  32  rs operand.
REQ-008 rt_data  in  32  rt operand.
REQ-009 hilo_valid_out  in  1  done flag from the HI/LO unit.
REQ-010 hi_in  in  32  HI value from the HI/LO unit.
REQ-011 lo_in  in  32  LO value from the HI/LO unit.
REQ-012 opcode  out  6  operation code to the HI/LO unit; 6'b000000 means idle.
REQ-013 a  out  32  operand a to the HI/LO unit (registered rs).
REQ-014 b  out  32  operand b to the HI/LO unit (registered rt).
REQ-015 valid_in  out  1  one-cycle start pulse for div/divu.
REQ-016 stall  out  1  upstream must hold its instruction.
REQ-017 rd_data  out  32  mfhi/mflo result.
REQ-018 rd_valid  out  1  one-cycle qualifier for rd_data.
REQ-019 div_timeout  out  1  one-cycle pulse when a divide is aborted.

Function
REQ-020 SHALL accept an instruction only when the state is IDLE and instr_valid=1; stall SHALL equal (state != IDLE).
REQ-021 SHALL decode these funct codes: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011. Any other funct SHALL be ignored, with no state change.
REQ-022 On accept, a/b SHALL latch rs_data/rt_data and opcode SHALL latch funct; all three SHALL stay stable until return to IDLE.
REQ-023 States: IDLE, MOVE, MUL_HOLD, DIV_START, DIV_RUN, DIV_FIN, READ.
REQ-024 mthi/mtlo: IDLE->MOVE (opcode driven for 1 cycle) ->IDLE.
REQ-025 mult/multu: IDLE->MOVE->MUL_HOLD, then ->IDLE. Opcode SHALL be driven for exactly 2 cycles, because the HI/LO unit commits the product one cycle after computing it.
REQ-026 div/divu sequence:
- IDLE->DIV_START, with valid_in=1 for that cycle only.
- DIV_START->DIV_RUN.
- DIV_RUN->DIV_FIN on the first cycle hilo_valid_out=1.
- DIV_FIN holds opcode for 1 further cycle (so the unit commits HI/LO), then ->IDLE.
REQ-027 In DIV_RUN, a 6-bit counter SHALL count cycles. On reaching DIV_TIMEOUT: pulse div_timeout, opcode->0, ->IDLE. HI/LO contents are then undefined.
REQ-028 mfhi/mflo: IDLE->READ. In READ, opcode=0 and rd_data is registered from hi_in/lo_in. rd_valid=1 on the following cycle, together with the return to IDLE.
REQ-029 opcode SHALL be 0 in IDLE and READ. valid_in SHALL be 0 outside DIV_START.
REQ-030 Divide by zero SHALL be issued normally; results are architecturally undefined and completion relies on hilo_valid_out or the timeout.
REQ-031 If hilo_valid_out is asserted outside DIV_RUN, it SHALL be ignored.
REQ-032 If instr_valid is asserted while stall=1, it SHALL have no effect.

Reset
REQ-033 While reset=1, regardless of clk:
- state=IDLE
- opcode=0, a=0, b=0
- valid_in=0, stall=0
- rd_data=0, rd_valid=0, div_timeout=0
- counter=0
REQ-034 Reset asserted mid-divide SHALL abort the operation with no div_timeout pulse.

Structure
REQ-035 Funct constants and the state enum SHALL live in the shared package mips_cpu_pkg.
REQ-036 No sub-module is required; the timeout counter stays inline.

Verification
REQ-037 mthi rs=0x12345678, then mfhi -> rd_data=0x12345678, rd_valid 2 cycles after mfhi is accepted.
REQ-038 mult rs=0xFFFFFFFE (-2), rt=3 -> opcode held 2 cycles; then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFA.
REQ-039 divu rs=100, rt=7, with the real HI/LO unit attached -> single valid_in pulse, stall until DIV_FIN ends; then mflo=14, mfhi=2.
REQ-040 div rs=-7 (0xFFFFFFF9), rt=2 -> mflo=0xFFFFFFFD, mfhi=0xFFFFFFFF.
REQ-041 div, with a model whose hilo_valid_out is held at 0 -> div_timeout pulses after 40 DIV_RUN cycles and the state returns to IDLE.
REQ-042 Reset pulsed during DIV_RUN -> all outputs return to 0 immediately, and the next instr_valid is accepted.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the HI/LO issue logic:
// funct encodings, issue FSM states and decode helpers.
package mips_cpu_pkg;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        MUL_HOLD,
        DIV_START,
        DIV_RUN,
        DIV_FIN,
        READ
    } state_t;

    // IDLE doubles as "not a HI/LO instruction"
    function automatic state_t entry_state(input logic [5:0] f);
        state_t s;
        case (f)
            F_MFHI, F_MFLO:  s = READ;
            F_MTHI, F_MTLO:  s = MOVE;
            F_MULT, F_MULTU: s = MOVE;
            F_DIV, F_DIVU:   s = DIV_START;
            default:         s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic is_mult(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU);
    endfunction

    function automatic logic drives_opcode(input state_t s);
        logic d;
        case (s)
            MOVE, MUL_HOLD:             d = 1'b1;
            DIV_START, DIV_RUN, DIV_FIN: d = 1'b1;
            default:                    d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_cpu_hilo_issue.sv
// Issues HI/LO-class R-type instructions to the HI/LO unit,
// sequencing moves, multiplies, divides (with timeout) and reads.
module mips_cpu_hilo_issue
    import mips_cpu_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_valid_out,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [5:0]  opcode,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        valid_in,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_timeout
);

    localparam logic [5:0] CNT_LAST = 6'(DIV_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [5:0] cnt_q;
    logic       accept;
    logic       run_wait;
    logic       timeout_hit;

    assign accept = (state_q == IDLE) && instr_valid &&
                    (entry_state(funct) != IDLE);

    // completion wins over timeout on the same cycle
    assign run_wait    = (state_q == DIV_RUN) && !hilo_valid_out;
    assign timeout_hit = run_wait && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = entry_state(funct);
                end
            end
            MOVE: begin
                state_d = is_mult(op_q) ? MUL_HOLD : IDLE;
            end
            MUL_HOLD: begin
                state_d = IDLE;
            end
            DIV_START: begin
                state_d = DIV_RUN;
            end
            DIV_RUN: begin
                if (hilo_valid_out) begin
                    state_d = DIV_FIN;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DIV_FIN: begin
                state_d = IDLE;
            end
            READ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        opcode   = F_NONE;
        valid_in = 1'b0;
        stall    = (state_q != IDLE);
        if (drives_opcode(state_q)) begin
            opcode = op_q;
        end
        if (state_q == DIV_START) begin
            valid_in = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= F_NONE;
            a    <= '0;
            b    <= '0;
        end else if (accept) begin
            op_q <= funct;
            a    <= rs_data;
            b    <= rt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state_q == READ) begin
                rd_data  <= (op_q == F_MFHI) ? hi_in : lo_in;
                rd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            div_timeout <= 1'b0;
        end else begin
            div_timeout <= 1'b0;
            if (timeout_hit) begin
                cnt_q       <= '0;
                div_timeout <= 1'b1;
            end else if (run_wait) begin
                cnt_q <= cnt_q + 6'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule
